mem_arbiter: RTL and testbench

Shares one single-ported unified instruction/data memory between the fetch (F) stage and the memory (M) stage of the 5-stage RV32I pipeline. Runs a grant state machine and a wait-state counter, drives the memory port from latched request registers, and returns data with a one-cycle ready pulse. Raises per-stage stall outputs that the pipeline ORs into its existing stall/flush network alongside the hazard unit.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between fetch and memory stages; LATENCY+1 cycles request-to-ready.
// Requesters stall (Fo_stall/Mo_stall) until their ready pulse; MEM_ARB_RR_EN selects round-robin over fixed M priority.
module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset_x,
  input  logic          Fi_req,
  input  logic [AW-1:0] Fi_addr,
  input  logic          Fi_kill,
  output logic [31:0]   Fo_rdata,
  output logic          Fo_ready,
  output logic          Fo_stall,
  input  logic          Mi_req,
  input  logic          Mi_we,
  input  logic [3:0]    Mi_be,
  input  logic [AW-1:0] Mi_addr,
  input  logic [31:0]   Mi_wdata,
  output logic [31:0]   Mo_rdata,
  output logic          Mo_ready,
  output logic          Mo_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic          owner_m;
  logic          grant, grant_m;
  logic [CW-1:0] cnt;
  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;
  logic          killed;
  logic          f_want;
  logic          last_beat;
  logic          busy;

  assign f_want    = Fi_req & ~Fi_kill;
  assign busy      = (state == BUSY);
  assign last_beat = busy && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_m   = owner_m;
    case (state)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (Mi_req && f_want) begin
          grant   = 1'b1;
          grant_m = ~owner_m;
        end else if (Mi_req) begin
          grant   = 1'b1;
          grant_m = 1'b1;
        end else if (f_want) begin
          grant   = 1'b1;
          grant_m = 1'b0;
        end
`else
        if (Mi_req) begin
          grant   = 1'b1;
          grant_m = 1'b1;
        end else if (f_want) begin
          grant   = 1'b1;
          grant_m = 1'b0;
        end
`endif
        if (grant) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        // Only the other port may take over here; the owner's held request is stale.
        if (owner_m && f_want) begin
          grant   = 1'b1;
          grant_m = 1'b0;
        end else if (!owner_m && Mi_req) begin
          grant   = 1'b1;
          grant_m = 1'b1;
        end
        state_nxt = grant ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state     <= IDLE;
      owner_m   <= 1'b0;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= 4'h0;
      lat_wdata <= 32'h0;
      killed    <= 1'b0;
      Fo_rdata  <= 32'h0;
      Mo_rdata  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_m <= grant_m;
        cnt     <= '0;
        killed  <= 1'b0;
        if (grant_m) begin
          lat_addr  <= Mi_addr;
          lat_we    <= Mi_we;
          lat_be    <= Mi_be;
          lat_wdata <= Mi_wdata;
        end else begin
          lat_addr  <= Fi_addr;
          lat_we    <= 1'b0;
          lat_be    <= 4'hF;
          lat_wdata <= 32'h0;
        end
      end else if (busy) begin
        cnt <= cnt + CW'(1);
        // A redirected fetch still finishes its memory cycle but must not deliver data.
        if (!owner_m && Fi_kill) killed <= 1'b1;
        if (last_beat) begin
          if (owner_m && !lat_we) Mo_rdata <= mem_rdata;
          if (!owner_m && !killed && !Fi_kill) Fo_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_req   = busy;
  assign mem_we    = busy & lat_we;
  assign mem_be    = busy ? lat_be : 4'h0;
  assign mem_addr  = busy ? lat_addr : '0;
  assign mem_wdata = busy ? lat_wdata : 32'h0;

  assign Fo_ready = (state == DONE) & ~owner_m & ~killed;
  assign Mo_ready = (state == DONE) & owner_m;
  assign Fo_stall = Fi_req & ~Fo_ready & ~Fi_kill;
  assign Mo_stall = Mi_req & ~Mo_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=2 instance for most scenarios, LATENCY=1 instance for back-to-back loads.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_x = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h100: return 32'h00500093;
      32'h200: return 32'hDEADBEEF;
      32'h400: return 32'h00A00113;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // LATENCY=2 instance
  logic        Fi_req = 0, Fi_kill = 0, Mi_req = 0, Mi_we = 0;
  logic [31:0] Fi_addr = 0, Mi_addr = 0, Mi_wdata = 0;
  logic [3:0]  Mi_be = 0;
  logic [31:0] Fo_rdata, Mo_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        Fo_ready, Fo_stall, Mo_ready, Mo_stall, mem_req, mem_we;
  logic [3:0]  mem_be;

  always_comb mem_rdata = mem_model(mem_addr);

  mem_arbiter #(.LATENCY(2), .AW(32)) u_dut (
    .clk(clk), .reset_x(reset_x),
    .Fi_req(Fi_req), .Fi_addr(Fi_addr), .Fi_kill(Fi_kill),
    .Fo_rdata(Fo_rdata), .Fo_ready(Fo_ready), .Fo_stall(Fo_stall),
    .Mi_req(Mi_req), .Mi_we(Mi_we), .Mi_be(Mi_be), .Mi_addr(Mi_addr), .Mi_wdata(Mi_wdata),
    .Mo_rdata(Mo_rdata), .Mo_ready(Mo_ready), .Mo_stall(Mo_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // LATENCY=1 instance
  logic        l1_fi_req = 0, l1_fi_kill = 0, l1_mi_req = 0, l1_mi_we = 0;
  logic [31:0] l1_fi_addr = 0, l1_mi_addr = 0, l1_mi_wdata = 0;
  logic [3:0]  l1_mi_be = 0;
  logic [31:0] l1_fo_rdata, l1_mo_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic        l1_fo_ready, l1_fo_stall, l1_mo_ready, l1_mo_stall, l1_mem_req, l1_mem_we;
  logic [3:0]  l1_mem_be;

  always_comb l1_mem_rdata = mem_model(l1_mem_addr);

  mem_arbiter #(.LATENCY(1), .AW(32)) u_dut_l1 (
    .clk(clk), .reset_x(reset_x),
    .Fi_req(l1_fi_req), .Fi_addr(l1_fi_addr), .Fi_kill(l1_fi_kill),
    .Fo_rdata(l1_fo_rdata), .Fo_ready(l1_fo_ready), .Fo_stall(l1_fo_stall),
    .Mi_req(l1_mi_req), .Mi_we(l1_mi_we), .Mi_be(l1_mi_be), .Mi_addr(l1_mi_addr), .Mi_wdata(l1_mi_wdata),
    .Mo_rdata(l1_mo_rdata), .Mo_ready(l1_mo_ready), .Mo_stall(l1_mo_stall),
    .mem_req(l1_mem_req), .mem_we(l1_mem_we), .mem_be(l1_mem_be), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
  );

  task automatic test_reset();
    logic [137:0] outs;
    #12;
    outs = {Fo_rdata, Fo_ready, Fo_stall, Mo_rdata, Mo_ready, Mo_stall,
            mem_req, mem_we, mem_be, mem_addr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    checks++;
    if ({l1_mem_req, l1_mo_ready, l1_fo_ready, l1_mo_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_l1 got=%h exp=0", {l1_mem_req, l1_mo_ready, l1_fo_ready, l1_mo_rdata});
    end
    @(negedge clk);
    reset_x = 1'b1;
  endtask

  task automatic test_fetch();
    logic [2:0] got, exp;
    @(posedge clk); #1;
    Fi_req = 1; Fi_addr = 32'h100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp = {(c == 1 || c == 2), (c == 3), (c <= 2)};
      got = {mem_req, Fo_ready, Fo_stall};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL fetch_ctl c=%0d got=%b exp=%b (mem_req,Fo_ready,Fo_stall)", c, got, exp);
      end
      if (c == 1) begin
        checks++;
        if ({mem_addr, mem_we, mem_be} !== {32'h100, 1'b0, 4'hF}) begin
          failures++;
          $display("FAIL fetch_port got addr=%h we=%b be=%b exp addr=100 we=0 be=1111", mem_addr, mem_we, mem_be);
        end
      end
      if (c >= 3) begin
        checks++;
        if (Fo_rdata !== 32'h00500093) begin
          failures++;
          $display("FAIL fetch_data c=%0d got=%h exp=00500093", c, Fo_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) Fi_req = 0;
    end
  endtask

  task automatic test_priority();
    logic [4:0] got, exp;
    int m_done, f_done;
    logic [31:0] first_addr, second_addr;
    // Lone load first, so the last grant is M going into the contended case.
    @(posedge clk); #1;
    Mi_req = 1; Mi_we = 0; Mi_be = 4'hF; Mi_addr = 32'h200;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (Mo_ready !== (c == 3)) begin
        failures++;
        $display("FAIL load_ready c=%0d got=%b exp=%b", c, Mo_ready, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (Mo_rdata !== 32'hDEADBEEF) begin
          failures++;
          $display("FAIL load_data got=%h exp=deadbeef", Mo_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) Mi_req = 0;
    end
`ifdef MEM_ARB_RR_EN
    f_done = 3; m_done = 6; first_addr = 32'h104; second_addr = 32'h204;
`else
    m_done = 3; f_done = 6; first_addr = 32'h204; second_addr = 32'h104;
`endif
    @(posedge clk); #1;
    Mi_req = 1; Mi_addr = 32'h204; Fi_req = 1; Fi_addr = 32'h104;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp = {(c == 1 || c == 2 || c == 4 || c == 5), (c == m_done), (c == f_done), (c < m_done), (c < f_done)};
      got = {mem_req, Mo_ready, Fo_ready, Mo_stall, Fo_stall};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL prio_ctl c=%0d got=%b exp=%b (mem_req,Mo_ready,Fo_ready,Mo_stall,Fo_stall)", c, got, exp);
      end
      if (c == 1 || c == 4) begin
        checks++;
        if (mem_addr !== ((c == 1) ? first_addr : second_addr)) begin
          failures++;
          $display("FAIL prio_order c=%0d got=%h exp=%h", c, mem_addr, (c == 1) ? first_addr : second_addr);
        end
      end
      if (c == m_done) begin
        checks++;
        if (Mo_rdata !== 32'hA5A50204) begin
          failures++;
          $display("FAIL prio_mdata got=%h exp=a5a50204", Mo_rdata);
        end
      end
      if (c == f_done) begin
        checks++;
        if (Fo_rdata !== 32'hA5A50104) begin
          failures++;
          $display("FAIL prio_fdata got=%h exp=a5a50104", Fo_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == m_done) Mi_req = 0;
      if (c == f_done) Fi_req = 0;
    end
  endtask

  task automatic test_store();
    logic [2:0] got, exp;
    int busy_cycles = 0;
    @(posedge clk); #1;
    Mi_req = 1; Mi_we = 1; Mi_be = 4'b0011; Mi_addr = 32'h300; Mi_wdata = 32'h1234;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (mem_req) busy_cycles++;
      exp = {(c == 1 || c == 2), (c == 1 || c == 2), (c == 3)};
      got = {mem_req, mem_we, Mo_ready};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL store_ctl c=%0d got=%b exp=%b (mem_req,mem_we,Mo_ready)", c, got, exp);
      end
      if (c == 2) begin
        checks++;
        if ({mem_be, mem_addr, mem_wdata} !== {4'b0011, 32'h300, 32'h1234}) begin
          failures++;
          $display("FAIL store_port got be=%b addr=%h wdata=%h exp be=0011 addr=300 wdata=1234", mem_be, mem_addr, mem_wdata);
        end
      end
      if (c == 3 || c == 6) begin
        checks++;
        if (Mo_rdata !== 32'hA5A50204) begin
          failures++;
          $display("FAIL store_rdata_hold c=%0d got=%h exp=a5a50204", c, Mo_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 3) begin Mi_req = 0; Mi_we = 0; end
    end
    checks++;
    if (busy_cycles !== 2) begin
      failures++;
      $display("FAIL store_once got=%0d busy cycles exp=2", busy_cycles);
    end
  endtask

  task automatic test_kill();
    logic [2:0] got, exp;
    @(posedge clk); #1;
    Fi_req = 1; Fi_addr = 32'h180;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp = {(c == 1 || c == 2 || c == 5 || c == 6), (c == 7), (c <= 1 || (c >= 3 && c <= 6))};
      got = {mem_req, Fo_ready, Fo_stall};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL kill_ctl c=%0d got=%b exp=%b (mem_req,Fo_ready,Fo_stall)", c, got, exp);
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (Fo_rdata !== 32'hA5A50104) begin
          failures++;
          $display("FAIL kill_hold c=%0d got=%h exp=a5a50104", c, Fo_rdata);
        end
      end
      if (c == 5) begin
        checks++;
        if (mem_addr !== 32'h400) begin
          failures++;
          $display("FAIL kill_refetch_addr got=%h exp=400", mem_addr);
        end
      end
      if (c == 7) begin
        checks++;
        if (Fo_rdata !== 32'h00A00113) begin
          failures++;
          $display("FAIL kill_refetch_data got=%h exp=00a00113", Fo_rdata);
        end
      end
      @(posedge clk); #1;
      if (c == 1) Fi_kill = 1;
      if (c == 2) begin Fi_kill = 0; Fi_addr = 32'h400; end
      if (c == 7) Fi_req = 0;
    end
  endtask

  task automatic test_reset_mid();
    logic [137:0] outs;
    logic [1:0] got, exp;
    @(posedge clk); #1;
    Mi_req = 1; Mi_we = 0; Mi_addr = 32'h200;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy got=%b exp=1", mem_req);
    end
    #2;
    reset_x = 0; Mi_req = 0;
    #1;
    outs = {Fo_rdata, Fo_ready, Fo_stall, Mo_rdata, Mo_ready, Mo_stall,
            mem_req, mem_we, mem_be, mem_addr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h exp=0", outs);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, Mo_ready} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_held got=%b exp=00", {mem_req, Mo_ready});
    end
    reset_x = 1;
    @(posedge clk); #1;
    Mi_req = 1; Mi_addr = 32'h200;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp = {(c == 1 || c == 2), (c == 3)};
      got = {mem_req, Mo_ready};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rst_after_ctl c=%0d got=%b exp=%b (mem_req,Mo_ready)", c, got, exp);
      end
      if (c == 0 || c == 3) begin
        checks++;
        if (Mo_rdata !== ((c == 0) ? 32'h0 : 32'hDEADBEEF)) begin
          failures++;
          $display("FAIL rst_after_data c=%0d got=%h exp=%h", c, Mo_rdata, (c == 0) ? 32'h0 : 32'hDEADBEEF);
        end
      end
      @(posedge clk); #1;
      if (c == 3) Mi_req = 0;
    end
  endtask

  task automatic test_back_to_back_l1();
    logic [1:0] got, exp;
    logic [31:0] exp_data [3];
    int k = 0;
    exp_data[0] = 32'hDEADBEEF; exp_data[1] = 32'hA5A50204; exp_data[2] = 32'hA5A50208;
    @(posedge clk); #1;
    l1_mi_req = 1; l1_mi_we = 0; l1_mi_be = 4'hF; l1_mi_addr = 32'h200;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp = {(c % 3 == 1 && c < 9), (c % 3 == 2 && c < 9)};
      got = {l1_mem_req, l1_mo_ready};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL l1_ctl c=%0d got=%b exp=%b (mem_req,Mo_ready)", c, got, exp);
      end
      if (l1_mo_ready && k < 3) begin
        checks++;
        if (l1_mo_rdata !== exp_data[k]) begin
          failures++;
          $display("FAIL l1_data k=%0d got=%h exp=%h", k, l1_mo_rdata, exp_data[k]);
        end
        k++;
      end
      @(posedge clk); #1;
      if (l1_mo_ready || (c % 3 == 2)) begin
        if (k >= 3 || c >= 8) l1_mi_req = 0;
        else l1_mi_addr = 32'h200 + 32'(4 * k);
      end
    end
    checks++;
    if (k !== 3) begin
      failures++;
      $display("FAIL l1_count got=%0d loads exp=3", k);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_kill();
    test_reset_mid();
    test_back_to_back_l1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
